mem_wb_skid_stage: RTL and testbench
====================================

Name: mem_wb_skid_stage

Overview:
- Parametrised MEM->WB pipeline stage. Replaces a plain hold-on-stall register with a valid/ready handshake and a 2-entry skid buffer, so backpressure from writeback never makes the upstream ready combinationally depend on the downstream ready.
- Adds flush and byte-granular store-to-load forwarding merge, where the previous design replaced the whole word.
- Sits between the memory stage and the writeback/register-file write port.

Parameters:
XLEN, 32, data width of load/store data; must be a multiple of 8
PAYLOAD_W, 128, width of opaque sideband bundle (pc, exec result, instr id, ...) carried unmodified
NBYTES, XLEN/8, derived localparam, byte lanes of the forwarding mask

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  discard all held entries this cycle
in_valid  in  1  upstream has a beat
in_ready  out  1  stage can accept a beat
in_payload  in  PAYLOAD_W  sideband bundle
in_rd_addr  in  5  destination register
in_rd_valid  in  1  beat writes rd
in_mem_data  in  XLEN  load data from memory
fwd_hit  in  1  older store overlaps this load
fwd_data  in  XLEN  store data, lane-aligned
fwd_byte_mask  in  NBYTES  lanes supplied by the store
out_valid  out  1  beat available to writeback
out_ready  in  1  writeback accepts
out_payload  out  PAYLOAD_W  held sideband bundle
out_rd_addr  out  5  held rd
out_rd_we  out  1  register-file write enable
out_mem_data  out  XLEN  merged load data

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S. Each holds payload, rd_addr, rd_valid, merged data.
- State machine:
  - EMPTY: M and S invalid.
  - FULL: M valid, S invalid.
  - SKID: both valid.
- Accept and transfer:
  - accept = in_valid & in_ready.
  - xfer = out_valid & out_ready.
- Transitions:
  - EMPTY, accept -> FULL, load M.
  - FULL, accept & !xfer -> SKID, load S.
  - FULL, accept & xfer -> FULL, load M with the new beat.
  - FULL, !accept & xfer -> EMPTY.
  - SKID, xfer -> FULL, M <= S. No accept is possible in SKID.
  - Otherwise hold all contents, bit-for-bit.
- in_ready = (state != SKID). Decoded from the state register only, with no path from out_ready. out_valid = (state != EMPTY).
- Latency: a beat accepted at edge N appears on the outputs after edge N, so out_valid is seen at cycle N+1. Throughput is 1 beat/cycle when out_ready is held high.
- Merge, computed at capture:
  - For lane i, data[8i+7:8i] = (fwd_hit & fwd_byte_mask[i]) ? fwd_data lane i : in_mem_data lane i.
  - fwd_hit=0 ignores the mask.
  - The merged value is stored; the forwarding inputs are not re-sampled while the beat is held.
- out_rd_we = out_valid & M.rd_valid & (M.rd_addr != 0). x0 writes are suppressed here.
- Flush:
  - Synchronous. Takes priority over accept and xfer in the same cycle.
  - Next state is EMPTY and the beat offered that cycle is dropped.
  - Data registers may keep stale values; only the valids are cleared.
- Reset: state EMPTY.
  - out_valid=0, out_rd_we=0, in_ready=1.
  - out_payload, out_rd_addr and out_mem_data are all zero.
  - Reset mid-transfer discards both entries.
- Stall from a cache miss is expressed upstream as in_valid=0 and downstream as out_ready=0. There is no separate stall port.
- Invariant: no beat is ever duplicated or reordered. S is always older than any later accept.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_FULL, ST_SKID);
  - the REG_ADDR_W=5 constant;
  - a function byte_merge(mem, fwd, mask, hit) that the memory-stage load aligner also reuses.
- One natural sub-module: pipe_skid_entry, a single entry register with load-enable and valid, instantiated twice for M and S.
- The merge stays combinational in the top module.

Test Plan:
- Reset release, then in_valid=1 with rd=5, mem_data=0x11223344, out_ready=1. Required: out_valid on the next cycle, out_mem_data=0x11223344, out_rd_we=1, in_ready stays 1.
- Merge: in_mem_data=0xAABBCCDD, fwd_hit=1, fwd_data=0x11223344, mask=4'b0101. Required: out_mem_data=0xAA22CC44. The same stimulus with fwd_hit=0 gives 0xAABBCCDD.
- Backpressure: out_ready=0, push beats A, B, C back-to-back. Required:
  - state SKID after B; in_ready=0 on the cycle after B is accepted; C is held upstream.
  - Raising out_ready then drains A, B, C in order with no duplicates.
- Flush in SKID with in_valid=1 the same cycle. Required: next cycle out_valid=0, in_ready=1, and the offered beat is never output.
- rd=0 beat with rd_valid=1. Required: out_valid=1, out_rd_we=0.
- Async rst asserted mid-transfer, between clock edges, in FULL. Required: out_valid=0 and out_mem_data=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and helpers for the MEM/WB boundary.
// Also used by the memory-stage load aligner for byte merging.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

    // One byte lane: the store wins only when it overlaps and covers the lane.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] mem,
        input logic [7:0] fwd,
        input logic       mask,
        input logic       hit
    );
        return (hit && mask) ? fwd : mem;
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// Single pipeline entry: data register plus valid flag.
// Clear drops only the valid; data keeps its last value.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clr,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage with a 2-entry skid buffer, flush and byte-lane
// store-to-load forwarding merge applied at capture.
module mem_wb_skid_stage
    import pipe_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int PAYLOAD_W = 128,
    localparam int NBYTES    = XLEN / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_rd_valid,
    input  logic [XLEN-1:0]       in_mem_data,
    input  logic                  fwd_hit,
    input  logic [XLEN-1:0]       fwd_data,
    input  logic [NBYTES-1:0]     fwd_byte_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PAYLOAD_W-1:0]  out_payload,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_rd_we,
    output logic [XLEN-1:0]       out_mem_data
);

    localparam int EW = PAYLOAD_W + REG_ADDR_W + 1 + XLEN;

    skid_state_e r_state;
    skid_state_e w_state_nxt;

    logic          w_accept;
    logic          w_xfer;
    logic          w_m_load;
    logic          w_m_clr;
    logic          w_m_from_s;
    logic          w_s_load;
    logic          w_s_clr;
    logic          w_m_valid;
    logic          w_s_valid;
    logic [XLEN-1:0] w_merged;
    logic [EW-1:0] w_in_entry;
    logic [EW-1:0] w_m_in;
    logic [EW-1:0] w_m_data;
    logic [EW-1:0] w_s_data;

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        assign w_merged[8*i +: 8] = byte_merge(in_mem_data[8*i +: 8],
                                               fwd_data[8*i +: 8],
                                               fwd_byte_mask[i],
                                               fwd_hit);
    end

    assign w_in_entry = {in_payload, in_rd_addr, in_rd_valid, w_merged};

    // Handshake decoded from registered state only, never from out_ready.
    assign in_ready  = (r_state != ST_SKID);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_xfer    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_load    = 1'b0;
        w_m_clr     = 1'b0;
        w_m_from_s  = 1'b0;
        w_s_load    = 1'b0;
        w_s_clr     = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_m_clr     = 1'b1;
            w_s_clr     = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_m_load    = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_xfer) begin
                        w_m_load = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_SKID;
                        w_s_load    = 1'b1;
                    end else if (w_xfer) begin
                        w_state_nxt = ST_EMPTY;
                        w_m_clr     = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (w_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_m_load    = 1'b1;
                        w_m_from_s  = 1'b1;
                        w_s_clr     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_m_in = w_m_from_s ? w_s_data : w_in_entry;

    pipe_skid_entry #(.W(EW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clr   (w_m_clr),
        .i_data  (w_m_in),
        .o_valid (w_m_valid),
        .o_data  (w_m_data)
    );

    pipe_skid_entry #(.W(EW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s_load),
        .i_clr   (w_s_clr),
        .i_data  (w_in_entry),
        .o_valid (w_s_valid),
        .o_data  (w_s_data)
    );

    assign out_payload  = w_m_data[EW-1 -: PAYLOAD_W];
    assign out_rd_addr  = w_m_data[XLEN+1 +: REG_ADDR_W];
    assign out_mem_data = w_m_data[XLEN-1:0];
    // x0 is hardwired zero, so its writes never reach the register file.
    assign out_rd_we    = out_valid & w_m_valid & w_m_data[XLEN]
                        & (out_rd_addr != '0);

    always @(posedge clk) begin
        if (!rst) begin
            assert (w_s_valid == (r_state == ST_SKID));
        end
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Randomized and directed bench for mem_wb_skid_stage.
// Reference model is a bounded FIFO of merged beats.
module tb_mem_wb_skid_stage;

    localparam int XLEN = 32;
    localparam int PW   = 128;
    localparam int NB   = XLEN / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   in_payload;
    logic [4:0]      in_rd_addr;
    logic            in_rd_valid;
    logic [XLEN-1:0] in_mem_data;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic [NB-1:0]   fwd_byte_mask;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   out_payload;
    logic [4:0]      out_rd_addr;
    logic            out_rd_we;
    logic [XLEN-1:0] out_mem_data;

    mem_wb_skid_stage #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_payload    (in_payload),
        .in_rd_addr    (in_rd_addr),
        .in_rd_valid   (in_rd_valid),
        .in_mem_data   (in_mem_data),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
        .fwd_byte_mask (fwd_byte_mask),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_payload   (out_payload),
        .out_rd_addr   (out_rd_addr),
        .out_rd_we     (out_rd_we),
        .out_mem_data  (out_mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0]   payload;
        logic [4:0]      rd;
        logic            rdv;
        logic [XLEN-1:0] data;
    } beat_t;

    beat_t q[$];
    logic [XLEN-1:0] got[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [PW-1:0] obs,
                       input logic [PW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] merge_ref(
        input logic [XLEN-1:0] mem, input logic [XLEN-1:0] fwd,
        input logic [NB-1:0] mask, input logic hit);
        logic [XLEN-1:0] r;
        r = mem;
        if (hit)
            for (int b = 0; b < NB; b++)
                if (mask[b]) r[8*b +: 8] = fwd[8*b +: 8];
        return r;
    endfunction

    task automatic check_outputs();
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("payload", out_payload, q[0].payload);
            chk("rd_addr", out_rd_addr, q[0].rd);
            chk("mem_data", out_mem_data, q[0].data);
            chk("rd_we", out_rd_we, q[0].rdv && q[0].rd != 0);
        end else begin
            chk("rd_we_idle", out_rd_we, 1'b0);
        end
    endtask

    task automatic cycle();
        int n;
        beat_t b;
        check_outputs();
        if (out_valid && out_ready) got.push_back(out_mem_data);
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            n = q.size();
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2) begin
                b.payload = in_payload;
                b.rd      = in_rd_addr;
                b.rdv     = in_rd_valid;
                b.data    = merge_ref(in_mem_data, fwd_data,
                                      fwd_byte_mask, fwd_hit);
                q.push_back(b);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd,
                         input logic [XLEN-1:0] md);
        in_valid    = v;
        in_rd_addr  = rd;
        in_rd_valid = 1'b1;
        in_mem_data = md;
        in_payload  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle_drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fwd_hit   = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        fwd_hit = 1'b0;
        fwd_data = '0;
        fwd_byte_mask = '0;
        drive(1'b0, 5'd0, '0);
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rd_we", out_rd_we, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_payload", out_payload, '0);
        chk("rst_rd_addr", out_rd_addr, '0);
        chk("rst_mem_data", out_mem_data, '0);
        @(negedge clk);
        rst = 1'b0;

        // basic beat, 1-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 5'd5, 32'h11223344);
        cycle();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_data", out_mem_data, 32'h11223344);
        chk("t1_we", out_rd_we, 1'b1);
        chk("t1_ready", in_ready, 1'b1);
        cycle();

        // forwarding merge
        fwd_data = 32'h11223344;
        fwd_byte_mask = 4'b0101;
        fwd_hit = 1'b1;
        drive(1'b1, 5'd7, 32'hAABBCCDD);
        cycle();
        chk("merge_hit", out_mem_data, 32'hAA22CC44);
        fwd_hit = 1'b0;
        drive(1'b1, 5'd7, 32'hAABBCCDD);
        cycle();
        chk("merge_nohit", out_mem_data, 32'hAABBCCDD);
        idle_drain(2);

        // backpressure A, B, C
        out_ready = 1'b0;
        got.delete();
        drive(1'b1, 5'd1, 32'h0000000A);
        cycle();
        drive(1'b1, 5'd2, 32'h0000000B);
        cycle();
        chk("bp_ready_low", in_ready, 1'b0);
        drive(1'b1, 5'd3, 32'h0000000C);
        cycle();
        chk("bp_c_held", q.size(), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (in_valid && in_ready) begin
                cycle();
                in_valid = 1'b0;
            end else begin
                cycle();
            end
        end
        chk("bp_count", got.size(), 3);
        chk("bp_first", got.size() > 0 ? got[0] : '1, 32'h0000000A);
        chk("bp_second", got.size() > 1 ? got[1] : '1, 32'h0000000B);
        chk("bp_third", got.size() > 2 ? got[2] : '1, 32'h0000000C);

        // flush in SKID with an offered beat
        out_ready = 1'b0;
        drive(1'b1, 5'd4, 32'h00000001);
        cycle();
        drive(1'b1, 5'd4, 32'h00000002);
        cycle();
        flush = 1'b1;
        drive(1'b1, 5'd4, 32'hDEADBEEF);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ready", in_ready, 1'b1);
        got.delete();
        idle_drain(3);
        chk("fl_dropped", got.size(), 0);

        // x0 write suppression
        drive(1'b1, 5'd0, 32'h12345678);
        cycle();
        in_valid = 1'b0;
        chk("x0_valid", out_valid, 1'b1);
        chk("x0_we", out_rd_we, 1'b0);
        idle_drain(2);

        // async reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 5'd9, 32'hCAFEF00D);
        cycle();
        in_valid = 1'b0;
        chk("ar_full", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_data", out_mem_data, '0);
        chk("ar_ready", in_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 30) == 0);
            in_payload = {$urandom, $urandom, $urandom, $urandom};
            in_rd_addr = 5'($urandom_range(0, 31));
            in_rd_valid = 1'($urandom);
            in_mem_data = $urandom;
            fwd_hit = 1'($urandom);
            fwd_data = $urandom;
            fwd_byte_mask = NB'($urandom);
            cycle();
        end
        flush = 1'b0;
        idle_drain(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
